// File: rtl/selector_pkg.sv
// Shared widths, table entry type, FSM state and edge-cost helper for family_selector.
package selector_pkg;

  localparam int unsigned N_MEMBERS   = 5;
  localparam int unsigned N_GENES     = 30;
  localparam int unsigned GENE_W      = 5;
  localparam int unsigned COORD_W     = 8;
  localparam int unsigned COST_W      = 16;
  localparam int unsigned MEMBER_W    = N_GENES * GENE_W;
  localparam int unsigned FAMILY_W    = N_MEMBERS * MEMBER_W;
  localparam int unsigned TABLE_DEPTH = 2 ** GENE_W;
  localparam int unsigned ENTRY_W     = 2 * COORD_W;
  localparam int unsigned MIDX_W      = 3;
  localparam int unsigned GIDX_W      = 5;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    CMP,
    DONE
  } state_t;

  // Manhattan distance between two stops; at most 2*(2**COORD_W-1).
  function automatic logic [COST_W-1:0] edge_cost(input coord_t a, input coord_t b);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = (a.x > b.x) ? (a.x - b.x) : (b.x - a.x);
    dy = (a.y > b.y) ? (a.y - b.y) : (b.y - a.y);
    return COST_W'(dx) + COST_W'(dy);
  endfunction

endpackage

// File: rtl/coord_table.sv
// 32-entry {x,y} coordinate register file: one write port, two combinational read ports.
module coord_table
  import selector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [GENE_W-1:0] i_addr,
  input  coord_t            i_data,
  input  logic [GENE_W-1:0] i_addr_a,
  input  logic [GENE_W-1:0] i_addr_b,
  output coord_t            o_data_a_c,
  output coord_t            o_data_b_c
);

  coord_t r_mem [TABLE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  assign o_data_a_c = r_mem[i_addr_a];
  assign o_data_b_c = r_mem[i_addr_b];

endmodule

// File: rtl/family_selector.sv
// Scores each family member as a route over the coordinate table and keeps the cheapest one.
// Optional CLOSED_TOUR_EN adds the closing edge (last gene back to gene 0) to every route.
module family_selector
  import selector_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [FAMILY_W-1:0] family,
  input  logic                coord_we,
  input  logic [GENE_W-1:0]   coord_addr,
  input  logic [ENTRY_W-1:0]  coord_data,
  output logic [MEMBER_W-1:0] best_member,
  output logic [COST_W-1:0]   best_cost,
  output logic [MIDX_W-1:0]   best_idx,
  output logic                busy,
  output logic                done
);

`ifdef CLOSED_TOUR_EN
  localparam int unsigned LAST_EDGE = N_GENES - 1;
`else
  localparam int unsigned LAST_EDGE = N_GENES - 2;
`endif
  localparam logic [GIDX_W-1:0] LAST_G      = GIDX_W'(LAST_EDGE);
  localparam logic [GIDX_W-1:0] LAST_GENE   = GIDX_W'(N_GENES - 1);
  localparam logic [MIDX_W-1:0] LAST_MEMBER = MIDX_W'(N_MEMBERS - 1);

  state_t                r_state,       w_state_nxt;
  logic [FAMILY_W-1:0]   r_family,      w_family_nxt;
  logic [MIDX_W-1:0]     r_m,           w_m_nxt;
  logic [GIDX_W-1:0]     r_g,           w_g_nxt;
  logic [COST_W-1:0]     r_acc,         w_acc_nxt;
  logic [MEMBER_W-1:0]   r_best_member, w_best_member_nxt;
  logic [COST_W-1:0]     r_best_cost,   w_best_cost_nxt;
  logic [MIDX_W-1:0]     r_best_idx,    w_best_idx_nxt;
  logic                  r_busy,        w_busy_nxt;
  logic                  r_done,        w_done_nxt;

  logic [MEMBER_W-1:0]   w_member;
  logic [GIDX_W-1:0]     w_g_b;
  logic [GENE_W-1:0]     w_gene_a;
  logic [GENE_W-1:0]     w_gene_b;
  coord_t                w_coord_a;
  coord_t                w_coord_b;
  logic                  w_tbl_we;

  // Current member and the two stops of the edge under evaluation.
  assign w_member = MEMBER_W'(r_family >> (MEMBER_W * 32'(r_m)));
  assign w_g_b    = (r_g == LAST_GENE) ? '0 : (r_g + GIDX_W'(1));
  assign w_gene_a = GENE_W'(w_member >> (GENE_W * 32'(r_g)));
  assign w_gene_b = GENE_W'(w_member >> (GENE_W * 32'(w_g_b)));

  // Table may only change while no route is being scored.
  assign w_tbl_we = coord_we && (r_state == IDLE);

  coord_table u_coord_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_tbl_we),
    .i_addr     (coord_addr),
    .i_data     (coord_t'(coord_data)),
    .i_addr_a   (w_gene_a),
    .i_addr_b   (w_gene_b),
    .o_data_a_c (w_coord_a),
    .o_data_b_c (w_coord_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_family      <= '0;
      r_m           <= '0;
      r_g           <= '0;
      r_acc         <= '0;
      r_best_member <= '0;
      r_best_cost   <= '0;
      r_best_idx    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_family      <= w_family_nxt;
      r_m           <= w_m_nxt;
      r_g           <= w_g_nxt;
      r_acc         <= w_acc_nxt;
      r_best_member <= w_best_member_nxt;
      r_best_cost   <= w_best_cost_nxt;
      r_best_idx    <= w_best_idx_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_family_nxt      = r_family;
    w_m_nxt           = r_m;
    w_g_nxt           = r_g;
    w_acc_nxt         = r_acc;
    w_best_member_nxt = r_best_member;
    w_best_cost_nxt   = r_best_cost;
    w_best_idx_nxt    = r_best_idx;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_family_nxt = family;
          w_state_nxt  = LOAD;
        end
      end
      LOAD: begin
        w_m_nxt     = '0;
        w_g_nxt     = '0;
        w_acc_nxt   = '0;
        w_state_nxt = EVAL;
      end
      EVAL: begin
        w_acc_nxt = r_acc + edge_cost(w_coord_a, w_coord_b);
        if (r_g == LAST_G) begin
          w_state_nxt = CMP;
        end else begin
          w_g_nxt = r_g + GIDX_W'(1);
        end
      end
      CMP: begin
        // Strict less-than keeps the lowest index on ties.
        if ((r_m == '0) || (r_acc < r_best_cost)) begin
          w_best_cost_nxt   = r_acc;
          w_best_idx_nxt    = r_m;
          w_best_member_nxt = w_member;
        end
        if (r_m == LAST_MEMBER) begin
          w_state_nxt = DONE;
        end else begin
          w_m_nxt     = r_m + MIDX_W'(1);
          w_g_nxt     = '0;
          w_acc_nxt   = '0;
          w_state_nxt = EVAL;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == EVAL) || (w_state_nxt == CMP);
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign best_member = r_best_member;
  assign best_cost   = r_best_cost;
  assign best_idx    = r_best_idx;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
